// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 12-bit accumulator CPU.
// Ports: clk/rst (async active-low), opcode, N/Z/C/V flags, mem_ready,
//   resume; datapath strobes mar_load/mar_sel, mem_rd/mem_wr, ir_load,
//   mdr_load, pc_inc, pc_load, ACLOAD, ac_we, alu_op; halted, bus_err.
module cpu_control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       mem_ready,
  input  logic       resume,
  output logic       mar_load,
  output logic       mar_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ACLOAD,
  output logic       ac_we,
  output logic [3:0] alu_op,
  output logic       halted,
  output logic       bus_err
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JN   = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JV   = 4'h8;
  localparam logic [3:0] OP_NOTA = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH_ADDR,
    S_FETCH_MEM,
    S_DECODE,
    S_OP_ADDR,
    S_OP_MEM,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       is_jump;
  logic       take;
  logic       timeout;

  always_comb begin
    is_jump = 1'b1;
    take    = 1'b0;
    unique case (opcode)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = Z;
      OP_JN:   take = N;
      OP_JC:   take = C;
      OP_JV:   take = V;
      default: is_jump = 1'b0;
    endcase
  end

  // mem_ready in the limit cycle wins over the timeout
  assign timeout = !mem_ready && (wait_cnt == TMO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RST;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      unique case (state)
        S_RST: state <= S_FETCH_ADDR;
        S_FETCH_ADDR: begin
          state    <= S_FETCH_MEM;
          wait_cnt <= 8'd0;
        end
        S_FETCH_MEM: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (is_jump || opcode == OP_NOP)
            state <= S_FETCH_ADDR;
          else if (opcode == OP_HLT)
            state <= S_HALT;
          else if (opcode == OP_NOTA)
            state <= S_EXEC;
          else
            state <= S_OP_ADDR;
        end
        S_OP_ADDR: begin
          state    <= (opcode == OP_STA) ? S_STORE : S_OP_MEM;
          wait_cnt <= 8'd0;
        end
        S_OP_MEM: begin
          if (mem_ready) begin
            state <= S_EXEC;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_STORE: begin
          if (mem_ready) begin
            state <= S_FETCH_ADDR;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_EXEC: state <= S_FETCH_ADDR;
        S_HALT: begin
          if (resume) begin
            bus_err <= 1'b0;
            state   <= S_FETCH_ADDR;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    ACLOAD   = 1'b0;
    ac_we    = 1'b0;
    alu_op   = 4'h0;
    halted   = 1'b0;
    unique case (state)
      S_FETCH_ADDR: mar_load = 1'b1;
      S_FETCH_MEM: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_DECODE: pc_load = take;
      S_OP_ADDR: begin
        mar_sel  = 1'b1;
        mar_load = 1'b1;
      end
      S_OP_MEM: begin
        mem_rd   = 1'b1;
        mdr_load = mem_ready;
      end
      S_EXEC: begin
        ACLOAD = 1'b1;
        ac_we  = (opcode != OP_CMP);
        alu_op = opcode;
      end
      S_STORE: mem_wr = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: scoreboard bench for cpu_control_unit.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_cpu_control_unit;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       C = 1'b0;
  logic       V = 1'b0;
  logic       mem_ready = 1'b0;
  logic       resume = 1'b0;
  logic       mar_load, mar_sel, mem_rd, mem_wr;
  logic       ir_load, mdr_load, pc_inc, pc_load;
  logic       ACLOAD, ac_we, halted, bus_err;
  logic [3:0] alu_op;

  cpu_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .N(N), .Z(Z), .C(C), .V(V),
    .mem_ready(mem_ready), .resume(resume),
    .mar_load(mar_load), .mar_sel(mar_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_load(ir_load), .mdr_load(mdr_load),
    .pc_inc(pc_inc), .pc_load(pc_load),
    .ACLOAD(ACLOAD), .ac_we(ac_we), .alu_op(alu_op),
    .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int we;
    int op;
  } ex_t;

  int   errors = 0;
  int   checks = 0;
  int   wait_cyc = 0;
  int   prog[$];
  int   q_rd[$];
  int   q_wr[$];
  int   q_len[$];
  int   q_pcl[$];
  int   q_mdr[$];
  int   q_halt[$];
  ex_t  q_ex[$];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic unexp(input string n, input int act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event got %0d expected none", n, act);
  endtask

  task automatic e_ex(input int c, input int we, input int op);
    ex_t e;
    e.cyc = c;
    e.we  = we;
    e.op  = op;
    q_ex.push_back(e);
  endtask

  function automatic int all_outs();
    return int'({mar_load, mar_sel, mem_rd, mem_wr, ir_load,
                 mdr_load, pc_inc, pc_load, ACLOAD, ac_we,
                 alu_op, halted, bus_err});
  endfunction

  // memory: ready after wait_cyc wait cycles of a held strobe
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst && (mem_rd || mem_wr)) begin
      mem_ready = (wcnt == wait_cyc);
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // instruction supply; HLT once the program is used up
  always @(negedge clk) begin
    if (ir_load) begin
      if (prog.size() > 0) opcode = 4'(prog.pop_front());
      else opcode = 4'hF;
    end
  end

  int cyc = 0;
  int rd_run = 0;
  int wr_run = 0;
  bit len_valid = 1'b0;
  bit halt_prev = 1'b0;
  ex_t ev;

  always @(negedge clk) begin
    if (!rst) begin
      rd_run = 0;
      wr_run = 0;
      len_valid = 1'b0;
      halt_prev = 1'b0;
      cyc = 0;
    end else begin
      if (mar_load && !mar_sel) begin
        if (len_valid) begin
          if (q_len.size() == 0) unexp("instr_len", cyc);
          else chk("instr_len", cyc, q_len.pop_front());
        end
        cyc = 1;
        len_valid = 1'b1;
      end else begin
        cyc++;
      end
      if (ir_load || pc_inc)
        chk("ir_pc_pair", int'(ir_load), int'(pc_inc));
      if (pc_load) begin
        if (q_pcl.size() == 0) unexp("pc_load", cyc);
        else chk("pc_load_cyc", cyc, q_pcl.pop_front());
      end
      if (mdr_load) begin
        if (q_mdr.size() == 0) unexp("mdr_load", cyc);
        else chk("mdr_load_cyc", cyc, q_mdr.pop_front());
      end
      if (ACLOAD) begin
        if (q_ex.size() == 0) unexp("aclload", cyc);
        else begin
          ev = q_ex.pop_front();
          chk("exec_cyc", cyc, ev.cyc);
          chk("exec_ac_we", int'(ac_we), ev.we);
          chk("exec_alu_op", int'(alu_op), ev.op);
        end
      end
      if (ac_we && !ACLOAD) unexp("ac_we_stray", int'(ac_we));
      if (mem_rd) rd_run++;
      else if (rd_run > 0) begin
        if (q_rd.size() == 0) unexp("mem_rd_len", rd_run);
        else chk("mem_rd_len", rd_run, q_rd.pop_front());
        rd_run = 0;
      end
      if (mem_wr) wr_run++;
      else if (wr_run > 0) begin
        if (q_wr.size() == 0) unexp("mem_wr_len", wr_run);
        else chk("mem_wr_len", wr_run, q_wr.pop_front());
        wr_run = 0;
      end
      if (halted && !halt_prev) begin
        if (q_halt.size() == 0) unexp("halt_entry", int'(bus_err));
        else chk("halt_bus_err", int'(bus_err), q_halt.pop_front());
      end
      halt_prev = halted;
      if (halted) len_valid = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("reset_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 chk("first_fetch", int'({mar_load, mar_sel}), 2);
  endtask

  task automatic wait_halt(input string n);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk(n, int'(halted), 1);
  endtask

  task automatic pulse_resume();
    @(negedge clk);
    #1 resume = 1'b1;
    @(negedge clk);
    #1 resume = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {N, Z, C, V} = f;
  endtask

  int hc;

  initial begin
    // ADD, zero wait
    prog = '{9};
    wait_cyc = 0;
    q_rd.push_back(1); q_rd.push_back(1);
    q_mdr.push_back(5); e_ex(6, 1, 9); q_len.push_back(6);
    q_rd.push_back(1); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_add");

    // CMP, two wait cycles per access
    prog = '{4};
    wait_cyc = 2;
    q_rd.push_back(3); q_rd.push_back(3);
    q_mdr.push_back(9); e_ex(10, 0, 4); q_len.push_back(10);
    q_rd.push_back(3); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_cmp");

    // jumps, N=0 Z=1 C=0 V=1
    prog = '{5, 6, 7, 8};
    wait_cyc = 0;
    set_flags(4'b0101);
    q_rd.push_back(1); q_pcl.push_back(3); q_len.push_back(3);
    q_rd.push_back(1); q_len.push_back(3);
    q_rd.push_back(1); q_len.push_back(3);
    q_rd.push_back(1); q_pcl.push_back(3); q_len.push_back(3);
    q_rd.push_back(1); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_jmp_a");

    // jumps, N=1 Z=0 C=1 V=0
    prog = '{5, 6, 7, 8};
    set_flags(4'b1010);
    q_rd.push_back(1); q_len.push_back(3);
    q_rd.push_back(1); q_pcl.push_back(3); q_len.push_back(3);
    q_rd.push_back(1); q_pcl.push_back(3); q_len.push_back(3);
    q_rd.push_back(1); q_len.push_back(3);
    q_rd.push_back(1); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_jmp_b");

    // flags clear: conditionals fall through, JMP taken, NOP
    prog = '{5, 6, 7, 8, 3, 0};
    set_flags(4'b0000);
    repeat (4) begin
      q_rd.push_back(1); q_len.push_back(3);
    end
    q_rd.push_back(1); q_pcl.push_back(3); q_len.push_back(3);
    q_rd.push_back(1); q_len.push_back(3);
    q_rd.push_back(1); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_jmp_c");

    // STA with 4 wait cycles, then NOTA
    prog = '{2, 14};
    wait_cyc = 4;
    q_rd.push_back(5); q_wr.push_back(5); q_len.push_back(13);
    q_rd.push_back(5); e_ex(8, 1, 14); q_len.push_back(8);
    q_rd.push_back(5); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_sta");

    // LDA with ready exactly at the timeout limit; stray resume
    prog = '{1};
    wait_cyc = TMO;
    q_rd.push_back(16); q_rd.push_back(16);
    q_mdr.push_back(35); e_ex(36, 1, 1); q_len.push_back(36);
    q_rd.push_back(16); q_halt.push_back(0);
    do_reset();
    repeat (10) @(negedge clk);
    #1 resume = 1'b1;
    @(negedge clk);
    #1 resume = 1'b0;
    wait_halt("halt_lda_edge");

    // fetch timeout, then resume and refetch
    prog = '{9};
    wait_cyc = 255;
    q_rd.push_back(TMO + 1); q_halt.push_back(1);
    do_reset();
    wait_halt("halt_timeout");
    chk("bus_err_set", int'(bus_err), 1);
    chk("rd_dropped", int'(mem_rd), 0);
    wait_cyc = 0;
    q_rd.push_back(1); q_rd.push_back(1);
    q_mdr.push_back(5); e_ex(6, 1, 9); q_len.push_back(6);
    q_rd.push_back(1); q_halt.push_back(0);
    pulse_resume();
    chk("bus_err_clr", int'(bus_err), 0);
    chk("refetch", int'({mar_load, mar_sel}), 2);
    wait_halt("halt_after_resume");

    // HLT holds until resume
    prog = '{};
    q_rd.push_back(1); q_halt.push_back(0);
    do_reset();
    wait_halt("halt_hlt");
    hc = 0;
    repeat (20) begin
      @(negedge clk);
      if (halted) hc++;
    end
    chk("halt_hold", hc, 20);
    prog.push_back(0);
    q_rd.push_back(1); q_len.push_back(3);
    q_rd.push_back(1); q_halt.push_back(0);
    pulse_resume();
    wait_halt("halt_after_nop");

    // async reset in OP_MEM
    prog = '{10};
    wait_cyc = 3;
    q_rd.push_back(4);
    do_reset();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir_load) break;
    end
    chk("sub_fetch", int'(ir_load), 1);
    repeat (3) @(negedge clk);
    chk("op_mem_rd", int'({mem_rd, mar_sel}), 2);
    #1 rst = 1'b0;
    #1 chk("midreset_outs", all_outs(), 0);
    wait_cyc = 0;
    q_rd.push_back(1); q_halt.push_back(0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 chk("refetch_after_rst", int'({mar_load, mar_sel}), 2);
    wait_halt("halt_after_rst");

    repeat (5) @(negedge clk);
    chk("left_rd", q_rd.size(), 0);
    chk("left_wr", q_wr.size(), 0);
    chk("left_len", q_len.size(), 0);
    chk("left_pcl", q_pcl.size(), 0);
    chk("left_mdr", q_mdr.size(), 0);
    chk("left_ex", q_ex.size(), 0);
    chk("left_halt", q_halt.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
